// File: rtl/sse_pair_feeder.sv
// sse_pair_feeder: buffers (A,B) sample pairs in a small FIFO and presents them to the SSE one pair per `next` strobe.
// Optional sticky `underrun` output when SSE_FEED_UNDERRUN_EN is defined.
module sse_pair_feeder #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  input  logic          sse_next,
  input  logic          sse_ready,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          sse_rst,
  output logic          stop,
  output logic          busy,
  output logic          frame_done,
`ifdef SSE_FEED_UNDERRUN_EN
  output logic          underrun,
`endif
  output logic [CW-1:0] pairs_sent
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state, state_nxt;
  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr, last_cnt;
  logic        full, empty, push, pop, has_last;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign has_last = (last_cnt != '0);

  assign sse_rst    = (state != RUN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // The pop that loads the first pair happens on the edge entering LOAD,
  // so the pair is already on A/B while the SSE is still held in reset.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (has_last || full) begin
          state_nxt = LOAD;
          pop       = 1'b1;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (stop) begin
          if (sse_ready) state_nxt = DONE;
        end else if (sse_next && !empty) begin
          pop = 1'b1;
        end
      end
      DONE: begin
        if (has_last) begin
          state_nxt = LOAD;
          pop       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_cnt   <= '0;
      A          <= '0;
      B          <= '0;
      stop       <= 1'b0;
      pairs_sent <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      last_cnt <= last_cnt + {{AW{1'b0}}, push && in_last} - {{AW{1'b0}}, pop && head.last};
      if (pop) begin
        A    <= head.a;
        B    <= head.b;
        stop <= head.last;
      end else if (state == RUN && state_nxt == DONE) begin
        stop <= 1'b0;
      end
      if (state_nxt == LOAD)
        pairs_sent <= {{(CW-1){1'b0}}, 1'b1};
      else if (pop && pairs_sent != '1)
        pairs_sent <= pairs_sent + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef SSE_FEED_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst)
      underrun <= 1'b0;
    else if (state_nxt == LOAD)
      underrun <= 1'b0;
    else if (state == RUN && !stop && sse_next && empty)
      underrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sse_pair_feeder.sv
// Bench for sse_pair_feeder: directed frames with literal expectations, then random traffic,
// all outputs compared every cycle against a queue-based frame model.
module tb_sse_pair_feeder;
  localparam int DW = 32, DEPTH = 8, CW = 16;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, sse_next = 1'b0, sse_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          in_ready, sse_rst, stop, busy, frame_done;
  logic [DW-1:0] A, B;
  logic [CW-1:0] pairs_sent;
`ifdef SSE_FEED_UNDERRUN_EN
  logic          underrun;
`endif

  always #5 clk = ~clk;

  sse_pair_feeder #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .sse_next(sse_next), .sse_ready(sse_ready),
    .A(A), .B(B), .sse_rst(sse_rst), .stop(stop), .busy(busy), .frame_done(frame_done),
`ifdef SSE_FEED_UNDERRUN_EN
    .underrun(underrun),
`endif
    .pairs_sent(pairs_sent)
  );

  typedef struct packed { logic last; logic [DW-1:0] a; logic [DW-1:0] b; } pair_t;
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DONE} mphase_t;

  pair_t         m_q[$];
  mphase_t       m_phase = M_IDLE;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic          m_stop = 1'b0, m_under = 1'b0;
  logic [CW-1:0] m_pairs = '0;
  int            checks = 0, failures = 0;
  bit            cmp_en = 1'b0;

  function automatic int n_last();
    int n = 0;
    foreach (m_q[i]) if (m_q[i].last) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of buffered pairs plus the pair currently shown to the SSE.
  always @(posedge clk) begin : model_upd
    pair_t hd;
    bit    do_pop, do_push;
    if (!rst) begin
      m_q.delete();
      m_phase = M_IDLE; m_a = '0; m_b = '0; m_stop = 1'b0; m_under = 1'b0; m_pairs = '0;
    end else begin
      do_push = in_valid && (m_q.size() < DEPTH);
      do_pop  = 1'b0;
      case (m_phase)
        M_IDLE: if (n_last() > 0 || m_q.size() == DEPTH) begin do_pop = 1'b1; m_phase = M_LOAD; end
        M_LOAD: m_phase = M_RUN;
        M_RUN: begin
          if (m_stop) begin
            if (sse_ready) begin m_phase = M_DONE; m_stop = 1'b0; end
          end else if (sse_next) begin
            if (m_q.size() > 0) do_pop = 1'b1;
            else m_under = 1'b1;
          end
        end
        M_DONE: if (n_last() > 0) begin do_pop = 1'b1; m_phase = M_LOAD; end
                else m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
      if (do_pop) begin
        hd = m_q.pop_front();
        m_a = hd.a; m_b = hd.b; m_stop = hd.last;
        if (m_phase == M_LOAD) begin m_pairs = 1; m_under = 1'b0; end
        else if (m_pairs != '1) m_pairs = m_pairs + 1'b1;
      end
      if (do_push) m_q.push_back({in_last, in_a, in_b});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("stop", stop, m_stop);
      chk("sse_rst", sse_rst, m_phase != M_RUN);
      chk("busy", busy, m_phase != M_IDLE);
      chk("frame_done", frame_done, m_phase == M_DONE);
      chk("pairs_sent", pairs_sent, m_pairs);
      chk("in_ready", in_ready, m_q.size() < DEPTH);
`ifdef SSE_FEED_UNDERRUN_EN
      chk("underrun", underrun, m_under);
`endif
    end
  end

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic l);
    int g = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
    while (m_q.size() == DEPTH && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    if (g >= 200) begin failures++; $display("FAIL push_timeout: fifo stayed full"); end
  endtask

  task automatic wait_phase(input mphase_t ph);
    int g = 0;
    while (m_phase != ph && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin failures++; $display("FAIL wait_phase: got %0d expected %0d", m_phase, ph); end
  endtask

  task automatic pulse_next();
    sse_next = 1'b1; @(negedge clk); sse_next = 1'b0;
  endtask

  task automatic pulse_ready();
    sse_ready = 1'b1; @(negedge clk); sse_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_A", A, 0); chk("rst_stop", stop, 0); chk("rst_sse_rst", sse_rst, 1);
    chk("rst_busy", busy, 0); chk("rst_in_ready", in_ready, 1); chk("rst_pairs", pairs_sent, 0);
    rst = 1'b1;

    // Three-pair frame, then ignored strobes.
    push(32'h40800000, 32'h40000000, 1'b0);
    push(32'h41000000, 32'h40800000, 1'b0);
    push(32'h41800000, 32'h41000000, 1'b1);
    wait_phase(M_LOAD);
    chk("t1_load_A", A, 32'h40800000); chk("t1_load_B", B, 32'h40000000);
    chk("t1_load_stop", stop, 0); chk("t1_load_sse_rst", sse_rst, 1);
    wait_phase(M_RUN);
    chk("t1_run_sse_rst", sse_rst, 0);
    pulse_next();
    chk("t1_p2_A", A, 32'h41000000); chk("t1_p2_stop", stop, 0);
    pulse_next();
    chk("t1_p3_A", A, 32'h41800000); chk("t1_p3_B", B, 32'h41000000);
    chk("t1_p3_stop", stop, 1); chk("t1_p3_pairs", pairs_sent, 3);
    pulse_next();
    chk("t6_ign_A", A, 32'h41800000); chk("t6_ign_pairs", pairs_sent, 3); chk("t6_ign_busy", busy, 1);
    pulse_ready();
    chk("t1_done", frame_done, 1); chk("t1_done_sse_rst", sse_rst, 1); chk("t1_done_pairs", pairs_sent, 3);
    @(negedge clk);
    chk("t1_done_once", frame_done, 0); chk("t1_idle_busy", busy, 0);
    pulse_ready();
    chk("t6_idle_ready_busy", busy, 0); chk("t6_idle_ready_done", frame_done, 0);

    // Full-triggered start and streaming refill.
    for (int i = 0; i < 8; i++) push(32'h1000 + i, 32'h2000 + i, 1'b0);
    chk("t2_full", in_ready, 0);
    push(32'h1008, 32'h2008, 1'b1);
    wait_phase(M_RUN);
    chk("t2_first_A", A, 32'h1000);
    repeat (8) pulse_next();
    chk("t2_ninth_A", A, 32'h1008); chk("t2_ninth_B", B, 32'h2008);
    chk("t2_ninth_stop", stop, 1); chk("t2_pairs", pairs_sent, 9);
    pulse_ready();
    @(negedge clk);

    // Back-to-back frames.
    push(32'h3001, 32'h4001, 1'b0);
    push(32'h3002, 32'h4002, 1'b1);
    push(32'h3003, 32'h4003, 1'b0);
    push(32'h3004, 32'h4004, 1'b1);
    wait_phase(M_RUN);
    pulse_next();
    chk("t3_x2_stop", stop, 1);
    pulse_ready();
    chk("t3_done", frame_done, 1);
    @(negedge clk);
    chk("t3_y1_A", A, 32'h3003); chk("t3_y1_busy", busy, 1);
    chk("t3_y1_pairs", pairs_sent, 1); chk("t3_y1_stop", stop, 0);
    wait_phase(M_RUN);
    pulse_next();
    pulse_ready();
    @(negedge clk);

    // Reset in the middle of a frame.
    push(32'h5001, 32'h6001, 1'b0);
    push(32'h5002, 32'h6002, 1'b0);
    push(32'h5003, 32'h6003, 1'b1);
    push(32'h5004, 32'h6004, 1'b1);
    wait_phase(M_RUN);
    pulse_next();
    chk("t4_pre_A", A, 32'h5002);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_A", A, 0); chk("t4_B", B, 0); chk("t4_stop", stop, 0); chk("t4_sse_rst", sse_rst, 1);
    chk("t4_in_ready", in_ready, 1); chk("t4_busy", busy, 0); chk("t4_done", frame_done, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_discard_busy", busy, 0);

    // Strobe with the FIFO drained.
    for (int i = 0; i < 8; i++) push(32'h6000 + i, 32'h7000 + i, 1'b0);
    wait_phase(M_RUN);
    repeat (7) pulse_next();
    chk("t5_last_A", A, 32'h6007);
    pulse_next();
    chk("t5_hold_A", A, 32'h6007); chk("t5_hold_B", B, 32'h7007);
    chk("t5_hold_stop", stop, 0); chk("t5_hold_pairs", pairs_sent, 8);
`ifdef SSE_FEED_UNDERRUN_EN
    chk("t5_underrun_set", underrun, 1);
`endif
    push(32'h6008, 32'h7008, 1'b1);
    pulse_next();
    chk("t5_tail_A", A, 32'h6008); chk("t5_tail_stop", stop, 1);
`ifdef SSE_FEED_UNDERRUN_EN
    chk("t5_underrun_sticky", underrun, 1);
`endif
    pulse_ready();
    @(negedge clk);
    push(32'h6100, 32'h7100, 1'b1);
    wait_phase(M_LOAD);
`ifdef SSE_FEED_UNDERRUN_EN
    chk("t5_underrun_clr", underrun, 0);
`endif
    chk("t5_next_A", A, 32'h6100);
    wait_phase(M_RUN);
    pulse_ready();
    @(negedge clk);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_a     = $urandom;
      in_b     = $urandom;
      in_last  = ($urandom_range(0, 5) == 0);
      sse_next = ($urandom_range(0, 2) == 0);
      if (m_phase == M_RUN && m_stop) sse_ready = ($urandom_range(0, 3) == 0);
      else if (m_phase == M_RUN)      sse_ready = 1'b0;
      else                            sse_ready = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; sse_next = 1'b0; sse_ready = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
